pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value loaded at reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, redirect target on misaligned control transfer.
REQ-004 SHALL have parameter CNT_W, default 32, taken-redirect counter width.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-006 SHALL have inputs: opcode 7 current instruction opcode; and_out 1 branch condition true; rs1_val XLEN JALR base; imm XLEN sign-extended immediate; stall 1 hold PC; halt_req 1 enter halt; resume 1 leave halt.
REQ-007 SHALL have outputs: pc XLEN current fetch address; pc_plus4 XLEN pc+4; pc_valid 1 pc fetchable; halted 1 in HALT; misalign 1 misaligned-target pulse; taken_cnt CNT_W redirect count.

Function
REQ-008 SHALL decode BRANCH=7'b1100011, JAL=7'b1101111, JALR=7'b1100111; all other opcodes are sequential.
REQ-009 SHALL compute target: BRANCH with and_out=1 -> pc+imm; JAL -> pc+imm; JALR -> (rs1_val+imm) with bit0 cleared; otherwise pc+4.
REQ-010 SHALL perform all adds modulo 2^XLEN; wrap from all-ones to low addresses without error.
REQ-011 SHALL implement FSM states BOOT, RUN, HALT.
REQ-012 BOOT: pc=RESET_VEC, pc_valid=0; unconditionally -> RUN next cycle, pc unchanged.
REQ-013 RUN: pc_valid=1; priority halt_req > stall > update.
REQ-014 RUN with halt_req=1: -> HALT, pc held, no counter update.
REQ-015 RUN with stall=1, halt_req=0: pc, taken_cnt held, state stays RUN.
REQ-016 RUN otherwise: pc <= target at next rising clk (one-cycle latency).
REQ-017 HALT: pc_valid=0, halted=1, pc held; halt_req and stall ignored; resume=1 -> RUN next cycle, PC resumes at held value.
REQ-018 taken_cnt SHALL increment by 1 on each RUN update cycle where a redirect (taken branch, JAL, JALR) occurs; saturates at all-ones.
REQ-019 pc_plus4 SHALL be combinational pc+4 at all times.
REQ-020 and_out SHALL be ignored for non-BRANCH opcodes.

Reset
REQ-021 rst_n=0 at a rising clk SHALL force: state BOOT, pc=RESET_VEC, pc_valid=0, halted=0, misalign=0, taken_cnt=0.
REQ-022 Reset SHALL take priority over every other input, including mid-HALT and mid-stall.

Configuration
REQ-023 SHALL compile misaligned-target trapping only when macro PC_MISALIGN_TRAP_EN is defined.
REQ-024 With PC_MISALIGN_TRAP_EN: a RUN update whose redirect target has bits[1:0]!=0 SHALL load pc=TRAP_VEC and assert misalign for exactly the following cycle; taken_cnt still increments.
REQ-025 Without PC_MISALIGN_TRAP_EN: target bits[1:0] SHALL be forced to 0 and misalign SHALL be tied 0.

Structure
REQ-026 Package pc_pkg SHALL hold the opcode constants and the FSM state enum type.
REQ-027 Sub-module pc_next SHALL contain the combinational target computation (REQ-009/010, misalign detect); pc_unit holds FSM, PC register, counter.

Verification
REQ-028 Reset, release -> cycle 1 pc=0, pc_valid=0; cycle 2 pc_valid=1, pc=0; sequential ops -> pc=4, 8, 12.
REQ-029 pc=0x10, BRANCH, imm=0x20, and_out=1 -> pc=0x30, taken_cnt=1; same with and_out=0 -> pc=0x14, taken_cnt unchanged.
REQ-030 pc=0x40, JALR, rs1_val=0x101, imm=0x4 -> pc=0x104 (bit0 cleared), taken_cnt+1; JAL imm=-8 (0xFFFF_FFF8) at pc=0x40 -> pc=0x38.
REQ-031 stall=1 for 3 cycles, then halt_req=1 with stall=1 -> pc held, halted=1, pc_valid=0; resume=1 -> RUN, pc continues from held value.
REQ-032 With macro: pc=0x40, JAL imm=0x2 -> pc=0x100, misalign=1 one cycle; without macro -> pc=0x40, misalign=0.
REQ-033 pc=0xFFFF_FFFC, sequential -> pc=0x0; rst_n=0 while halted -> pc=RESET_VEC, halted=0, taken_cnt=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared opcode constants and FSM state type for the program-counter unit.
package pc_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC target selection, redirect and misalign detection.
// Misaligned-target trapping is compiled in only with PC_MISALIGN_TRAP_EN.
module pc_next
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc,
  input  logic [6:0]      opcode,
  input  logic            and_out,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            trap
);

  logic [XLEN-1:0] target;

  always_comb begin
    redirect = 1'b0;
    target   = pc + XLEN'(4);
    case (opcode)
      OP_BRANCH: begin
        if (and_out) begin
          redirect = 1'b1;
          target   = pc + imm;
        end
      end
      OP_JAL: begin
        redirect = 1'b1;
        target   = pc + imm;
      end
      OP_JALR: begin
        redirect = 1'b1;
        target   = (rs1_val + imm) & ~XLEN'(1);
      end
      default: ;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_comb begin
    trap    = redirect && (target[1:0] != 2'b00);
    next_pc = trap ? TRAP_VEC : target;
  end
`else
  // Without trapping, the low address bits are simply dropped.
  logic unused_bits;
  assign unused_bits = ^{TRAP_VEC, target[1:0]};
  assign trap        = 1'b0;
  assign next_pc     = {target[XLEN-1:2], 2'b00};
`endif

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencing, PC register, redirect counter.
// Optional macro PC_MISALIGN_TRAP_EN enables misaligned-target trapping.
//
// state | meaning
// BOOT  | post-reset, pc=RESET_VEC not yet fetchable
// RUN   | fetching; pc advances unless stalled
// HALT  | pc frozen until resume
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             and_out,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t          state, state_nx;
  logic            update;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            trap;

  pc_next #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next (
    .pc       (pc),
    .opcode   (opcode),
    .and_out  (and_out),
    .rs1_val  (rs1_val),
    .imm      (imm),
    .next_pc  (next_pc),
    .redirect (redirect),
    .trap     (trap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    update   = 1'b0;
    case (state)
      ST_BOOT: state_nx = ST_RUN;
      ST_RUN: begin
        if (halt_req)    state_nx = ST_HALT;
        else if (!stall) update   = 1'b1;
      end
      ST_HALT: begin
        if (resume) state_nx = ST_RUN;
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      taken_cnt <= '0;
      misalign  <= 1'b0;
    end else begin
      // trap is constant 0 when trapping is compiled out
      misalign <= update & trap;
      if (update) begin
        pc <= next_pc;
        if (redirect && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_valid = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

endmodule
